fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter and fetch sequencer sitting directly upstream of the instruction memory. It generates the 9-bit instruction address every cycle, driving the memory's address input, and tracks sequential flow, absolute jumps, relative branches, stalls and halt. An optional hardware return stack supports subroutine call/return. The memory is combinational, so the instruction for `o_Address_Instruction` is available in the same cycle.

## Interface
- `PC_WIDTH`, 9, address width; matches the instruction memory address bus.
- `LAST_ADDR`, 255, highest valid instruction address; the memory holds `0..LAST_ADDR`.
- `RESET_VECTOR`, 0, PC value on reset.
- `STACK_DEPTH`, 4, return-stack entries; a power of two, 2..8.
- `i_Clock`, in, 1, single clock; all state updates on its rising edge.
- `i_Reset_n`, in, 1, asynchronous active-low reset.
- `i_Stall`, in, 1, hold PC and stack this cycle.
- `i_Halt`, in, 1, enter HALT.
- `i_Resume`, in, 1, leave HALT.
- `i_Jump`, in, 1, absolute jump to `i_Target`.
- `i_Branch`, in, 1, relative branch by `i_Offset`.
- `i_Call`, in, 1, push return address, then jump to `i_Target`.
- `i_Return`, in, 1, pop the return address into the PC.
- `i_Target`, in, `PC_WIDTH`, absolute target.
- `i_Offset`, in, `PC_WIDTH`, two's-complement branch offset.
- `o_Address_Instruction`, out, `PC_WIDTH`, current PC; drives the instruction memory address.
- `o_Fetch_Valid`, out, 1, the address is a live fetch.
- `o_Addr_Fault`, out, 1, sticky: a computed target exceeded `LAST_ADDR`.
- `o_Stack_Overflow`, out, 1, sticky.
- `o_Stack_Underflow`, out, 1, sticky.
- `o_Stack_Depth`, out, 4, current number of stack entries.

## Operation
- States and transitions:
  - BOOT → RUN unconditionally after one clock.
  - RUN → HALT on `i_Halt`.
  - HALT → RUN on `i_Resume` (`i_Halt` takes priority if both are asserted).
- `o_Fetch_Valid` is 1 only in RUN. It is also 1 during a RUN stall, because the held address remains a live fetch.
- Next-PC priority in RUN: `i_Stall` > `i_Return` > `i_Call` > `i_Jump` > `i_Branch` > increment.
  - Only the highest-priority request acts; the others are ignored that cycle.
- Increment: PC+1. At `LAST_ADDR` the PC wraps to 0; this wrap is not a fault.
- Branch target: PC + `i_Offset`, computed modulo 2^`PC_WIDTH`.
- Fault rule: a jump, call or branch target greater than `LAST_ADDR` sets `o_Addr_Fault`. In that case the PC loads `RESET_VECTOR`, not the target.
- Call:
  - Pushes the wrapped value of PC+1, then loads `i_Target`.
  - When the stack is full: no push, no jump, the PC increments, and `o_Stack_Overflow` is set.
- Return:
  - Pops the top entry into the PC.
  - When the stack is empty: the PC increments and `o_Stack_Underflow` is set.
- HALT: PC and stack are frozen; all requests are ignored.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous assert, including mid-operation) forces:
  - PC = `RESET_VECTOR`, state = BOOT, stack empty.
  - All flags = 0, `o_Fetch_Valid` = 0, `o_Stack_Depth` = 0.
- Flow requests are sampled at edge N. The new PC is visible after edge N, so there is one cycle of redirect latency.
- Sequential fetch has zero bubbles: a new address every cycle in RUN.
- First valid fetch: the cycle after the first edge following reset release, at address `RESET_VECTOR`.
- A call and a return on the same edge: return wins; the stack depth is decremented only.
- Flags assert on the edge that processes the offending request.

## Configuration
- `CALL_STACK_EN` defined: return stack, `i_Call`/`i_Return` and the stack flags operate as described above.
- `CALL_STACK_EN` undefined:
  - No stack storage is built.
  - `i_Call` and `i_Return` are ignored; the PC follows the next lower-priority request.
  - `o_Stack_Depth`, `o_Stack_Overflow` and `o_Stack_Underflow` are tied to 0.

## Structure
- Shared package `fetch_pkg`:
  - State enum (BOOT, RUN, HALT).
  - `PC_WIDTH` default.
  - `RESET_VECTOR` default.
  - Next-PC select enum.
- Sub-module `return_stack`: LIFO with push, pop, depth, full and empty. It is instantiated only under `CALL_STACK_EN`.

## Test plan
- Reset release, no requests → addresses 0,1,2,3 on successive cycles; `o_Fetch_Valid` goes 1 one edge after release.
- PC=255, no request → next 0; `o_Addr_Fault` stays 0.
- PC=10, `i_Branch` with `i_Offset`=9'h1F6 (−10) → PC=0. Then `i_Jump` to 300 → PC=`RESET_VECTOR`, `o_Addr_Fault`=1.
- PC=20, `i_Call` to 100 → PC=100, depth 1. Then `i_Return` → PC=21, depth 0. A further `i_Return` → PC=22, `o_Stack_Underflow`=1.
- Five calls with `STACK_DEPTH`=4 → the fifth increments instead of jumping; `o_Stack_Overflow`=1, depth stays 4.
- PC=40:
  - `i_Stall` for 3 cycles → PC held at 40, valid stays 1.
  - Then `i_Halt` → valid 0, PC frozen.
  - Reset asserted mid-HALT → PC=0, all flags 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch sequencer
package fetch_pkg;

    localparam int PC_WIDTH_DEF     = 9;
    localparam int RESET_VECTOR_DEF = 0;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_TARGET,
        SEL_BRANCH,
        SEL_POP,
        SEL_RESET
    } pc_sel_t;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO of return addresses with depth/full/empty status
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [3:0]       depth,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count;
    logic [AW-1:0]    top_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[AW-1:0]] <= push_data;
        end
    end

    assign top_idx = count[AW-1:0] - 1'b1;
    assign top     = mem[top_idx];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign depth   = 4'(count);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC and fetch sequencer; CALL_STACK_EN builds the return stack
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH     = PC_WIDTH_DEF,
    parameter int LAST_ADDR    = 255,
    parameter int RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int STACK_DEPTH  = 4
) (
    input  logic                i_Clock,
    input  logic                i_Reset_n,
    input  logic                i_Stall,
    input  logic                i_Halt,
    input  logic                i_Resume,
    input  logic                i_Jump,
    input  logic                i_Branch,
    input  logic                i_Call,
    input  logic                i_Return,
    input  logic [PC_WIDTH-1:0] i_Target,
    input  logic [PC_WIDTH-1:0] i_Offset,
    output logic [PC_WIDTH-1:0] o_Address_Instruction,
    output logic                o_Fetch_Valid,
    output logic                o_Addr_Fault,
    output logic                o_Stack_Overflow,
    output logic                o_Stack_Underflow,
    output logic [3:0]          o_Stack_Depth
);

    localparam logic [PC_WIDTH-1:0] LAST = PC_WIDTH'(LAST_ADDR);
    localparam logic [PC_WIDTH-1:0] RVEC = PC_WIDTH'(RESET_VECTOR);

    state_t              state, state_next;
    pc_sel_t             sel;
    logic [PC_WIDTH-1:0] pc, pc_next, pc_inc, br_target;
    logic                fault, fault_set;

    assign pc_inc    = (pc == LAST) ? '0 : pc + 1'b1;
    assign br_target = pc + i_Offset;

`ifdef CALL_STACK_EN
    logic [PC_WIDTH-1:0] stack_top;
    logic                push, pop, full, empty, ovf, unf, ovf_set, unf_set;

    return_stack #(.DEPTH(STACK_DEPTH), .WIDTH(PC_WIDTH)) u_stack (
        .clk       (i_Clock),
        .rst_n     (i_Reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .depth     (o_Stack_Depth),
        .full      (full),
        .empty     (empty)
    );

    assign o_Stack_Overflow  = ovf;
    assign o_Stack_Underflow = unf;
`else
    logic unused_stack_cfg;
    assign unused_stack_cfg  = ^{i_Call, i_Return, 4'(STACK_DEPTH)};
    assign o_Stack_Depth     = '0;
    assign o_Stack_Overflow  = 1'b0;
    assign o_Stack_Underflow = 1'b0;
`endif

    always_comb begin
        state_next = state;
        sel        = SEL_HOLD;
        fault_set  = 1'b0;
`ifdef CALL_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
`endif
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_HALT: if (!i_Halt && i_Resume) state_next = ST_RUN;
            ST_RUN: begin
                // Halt freezes the PC on the edge that takes it, ahead of any flow request.
                if (i_Halt) begin
                    state_next = ST_HALT;
                end else if (i_Stall) begin
                    sel = SEL_HOLD;
`ifdef CALL_STACK_EN
                end else if (i_Return) begin
                    if (empty) begin
                        sel     = SEL_INC;
                        unf_set = 1'b1;
                    end else begin
                        sel = SEL_POP;
                        pop = 1'b1;
                    end
                end else if (i_Call) begin
                    if (full) begin
                        sel     = SEL_INC;
                        ovf_set = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (i_Target > LAST) begin
                            sel       = SEL_RESET;
                            fault_set = 1'b1;
                        end else begin
                            sel = SEL_TARGET;
                        end
                    end
`endif
                end else if (i_Jump) begin
                    if (i_Target > LAST) begin
                        sel       = SEL_RESET;
                        fault_set = 1'b1;
                    end else begin
                        sel = SEL_TARGET;
                    end
                end else if (i_Branch) begin
                    if (br_target > LAST) begin
                        sel       = SEL_RESET;
                        fault_set = 1'b1;
                    end else begin
                        sel = SEL_BRANCH;
                    end
                end else begin
                    sel = SEL_INC;
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_INC:    pc_next = pc_inc;
            SEL_TARGET: pc_next = i_Target;
            SEL_BRANCH: pc_next = br_target;
            SEL_RESET:  pc_next = RVEC;
`ifdef CALL_STACK_EN
            SEL_POP:    pc_next = stack_top;
`endif
            default:    pc_next = pc;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= ST_BOOT;
            pc    <= RVEC;
            fault <= 1'b0;
`ifdef CALL_STACK_EN
            ovf   <= 1'b0;
            unf   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            pc    <= pc_next;
            fault <= fault | fault_set;
`ifdef CALL_STACK_EN
            ovf   <= ovf | ovf_set;
            unf   <= unf | unf_set;
`endif
        end
    end

    assign o_Address_Instruction = pc;
    assign o_Fetch_Valid         = (state == ST_RUN);
    assign o_Addr_Fault          = fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector table with expected-result queue for fetch_sequencer
module tb_fetch_sequencer;

`ifdef CALL_STACK_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall, halt, resume, jump, branch, call, ret;
    logic [8:0] target, offset;
    logic [8:0] addr;
    logic       valid, fault, ovf, unf;
    logic [3:0] depth;

    fetch_sequencer #(
        .PC_WIDTH(9), .LAST_ADDR(255), .RESET_VECTOR(0), .STACK_DEPTH(4)
    ) dut (
        .i_Clock               (clk),
        .i_Reset_n             (rst_n),
        .i_Stall               (stall),
        .i_Halt                (halt),
        .i_Resume              (resume),
        .i_Jump                (jump),
        .i_Branch              (branch),
        .i_Call                (call),
        .i_Return              (ret),
        .i_Target              (target),
        .i_Offset              (offset),
        .o_Address_Instruction (addr),
        .o_Fetch_Valid         (valid),
        .o_Addr_Fault          (fault),
        .o_Stack_Overflow      (ovf),
        .o_Stack_Underflow     (unf),
        .o_Stack_Depth         (depth)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit val, flt, ovf, unf;
        int dep;
    } exp_t;

    typedef struct {
        logic st, ha, re, jp, br, ca, rt;
        int   tgt, off;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   f_s = 0, o_s = 0, u_s = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic st, ha, re, jp, br, ca, rt, input int tgt, off,
                       input int pc, input bit val, input int dep);
        vec_t v;
        v.st = st; v.ha = ha; v.re = re; v.jp = jp; v.br = br; v.ca = ca; v.rt = rt;
        v.tgt = tgt; v.off = off;
        v.e.pc = pc; v.e.val = val; v.e.dep = dep;
        v.e.flt = f_s; v.e.ovf = o_s; v.e.unf = u_s;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, " pc"},    int'(addr),  e.pc);
        check({tag, " valid"}, int'(valid), int'(e.val));
        check({tag, " fault"}, int'(fault), int'(e.flt));
        check({tag, " ovf"},   int'(ovf),   int'(e.ovf));
        check({tag, " unf"},   int'(unf),   int'(e.unf));
        check({tag, " depth"}, int'(depth), e.dep);
    endtask

    initial begin
        exp_t e;
        {stall, halt, resume, jump, branch, call, ret} = '0;
        target = '0;
        offset = '0;

        //  st ha re jp br ca rt  tgt  off    pc               val dep
        add(0, 0, 0, 0, 0, 0, 0,   0,   0,    0,               1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0,   0,    1,               1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0,   0,    2,               1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0,   0,    3,               1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 255,   0,  255,               1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0,   0,    0,               1, 0);
        add(0, 0, 0, 1, 0, 0, 0,  10,   0,   10,               1, 0);
        add(0, 0, 0, 0, 1, 0, 0,   0, 'h1F6,  0,               1, 0);
        add(0, 0, 0, 0, 1, 0, 0,   0,   5,    5,               1, 0);
        add(0, 0, 0, 1, 0, 0, 0,  20,   0,   20,               1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 100,   0,   SE ? 100 : 21,    1, SE ? 1 : 0);
        add(0, 0, 0, 0, 0, 0, 1,   0,   0,   SE ? 21 : 22,     1, 0);
        u_s = SE;
        add(0, 0, 0, 0, 0, 0, 1,   0,   0,   SE ? 22 : 23,     1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 100,   0,   SE ? 100 : 24,    1, SE ? 1 : 0);
        add(0, 0, 0, 0, 0, 1, 0, 101,   0,   SE ? 101 : 25,    1, SE ? 2 : 0);
        add(0, 0, 0, 0, 0, 1, 0, 102,   0,   SE ? 102 : 26,    1, SE ? 3 : 0);
        add(0, 0, 0, 0, 0, 1, 0, 103,   0,   SE ? 103 : 27,    1, SE ? 4 : 0);
        o_s = SE;
        add(0, 0, 0, 0, 0, 1, 0, 200,   0,   SE ? 104 : 28,    1, SE ? 4 : 0);
        add(0, 0, 0, 0, 0, 1, 1,  50,   0,   SE ? 103 : 29,    1, SE ? 3 : 0);
        f_s = 1'b1;
        add(0, 0, 0, 1, 0, 0, 0, 300,   0,    0,               1, SE ? 3 : 0);
        add(0, 0, 0, 1, 0, 0, 0,  40,   0,   40,               1, SE ? 3 : 0);
        add(1, 0, 0, 0, 0, 0, 0,   0,   0,   40,               1, SE ? 3 : 0);
        add(1, 0, 0, 0, 0, 0, 0,   0,   0,   40,               1, SE ? 3 : 0);
        add(1, 0, 0, 1, 0, 0, 0,   7,   0,   40,               1, SE ? 3 : 0);
        add(0, 1, 0, 0, 0, 0, 0,   0,   0,   40,               0, SE ? 3 : 0);
        add(0, 0, 0, 1, 0, 1, 0,   5,   0,   40,               0, SE ? 3 : 0);
        add(0, 1, 1, 0, 0, 0, 0,   0,   0,   40,               0, SE ? 3 : 0);
        add(0, 0, 1, 0, 0, 0, 0,   0,   0,   40,               1, SE ? 3 : 0);
        add(0, 0, 0, 0, 0, 0, 0,   0,   0,   41,               1, SE ? 3 : 0);
        add(0, 1, 0, 0, 0, 0, 0,   0,   0,   41,               0, SE ? 3 : 0);

        #2;
        e = '{pc: 0, val: 0, flt: 0, ovf: 0, unf: 0, dep: 0};
        check_all("reset", e);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            stall  = vecs[i].st;  halt   = vecs[i].ha;  resume = vecs[i].re;
            jump   = vecs[i].jp;  branch = vecs[i].br;  call   = vecs[i].ca;
            ret    = vecs[i].rt;
            target = 9'(vecs[i].tgt);
            offset = 9'(vecs[i].off);
            exp_q.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d queue", i), 0, 1);
            end else begin
                e = exp_q.pop_front();
                check_all($sformatf("v%0d", i), e);
            end
            @(negedge clk);
        end
        {stall, halt, resume, jump, branch, call, ret} = '0;

        // Asynchronous reset while halted, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        e = '{pc: 0, val: 0, flt: 0, ovf: 0, unf: 0, dep: 0};
        check_all("halt_reset", e);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("boot0", '{pc: 0, val: 1, flt: 0, ovf: 0, unf: 0, dep: 0});
        @(posedge clk);
        #1;
        check_all("boot1", '{pc: 1, val: 1, flt: 0, ovf: 0, unf: 0, dep: 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
